mem_request_arbiter: RTL and testbench
======================================

// Module: mem_request_arbiter
// PURPOSE
//  Responder end of the datapath/cache interface. Services the pipeline's instruction-fetch and data requests
//  (imemREN, dmemREN/dmemWEN) against one shared single-port RAM of variable latency, returns ihit/dhit plus
//  load data, and reports halt/error status. Sits between datapath and the RAM model in the top-level system.
// PARAMETERS
//  WORD_W      32   data width of imemload/dmemload/dmemstore/ramstore/ramload
//  ADDR_W      32   address width of imemaddr/dmemaddr/ramaddr
//  TIMEOUT     255  max cycles in a service state without ramstate==ACCESS before ERROR (8-bit counter)
// PORTS
//  CLK        in   1       clock; all state updates on posedge
//  nRST       in   1       asynchronous, active-low reset
//  halt       in   1       datapath halt; stop servicing once idle
//  imemREN    in   1       instruction read request, held until ihit
//  imemaddr   in   ADDR_W  instruction address
//  dmemREN    in   1       data read request, held until dhit
//  dmemWEN    in   1       data write request, held until dhit
//  dmemaddr   in   ADDR_W  data address
//  dmemstore  in   WORD_W  data write value
//  ihit       out  1       1-cycle pulse: instruction fetch complete, imemload valid
//  dhit       out  1       1-cycle pulse: data access complete, dmemload valid on reads
//  imemload   out  WORD_W  fetched instruction (registered)
//  dmemload   out  WORD_W  loaded data (registered)
//  ramREN     out  1       RAM read strobe
//  ramWEN     out  1       RAM write strobe
//  ramaddr    out  ADDR_W  RAM address
//  ramstore   out  WORD_W  RAM write data
//  ramload    in   WORD_W  RAM read data, valid when ramstate==ACCESS
//  ramstate   in   2       0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//  halted     out  1       sticky: halt accepted, no further service
//  error      out  1       sticky: RAM ERROR or timeout seen
// BEHAVIOUR
//  Reset (async, nRST=0): state=IDLE; ihit,dhit,ram*,halted,error,imemload,dmemload,counter all 0.
//  States: IDLE, DSERV, ISERV, RESP, HALT, ERR.
//  IDLE: error-free and halt=1 -> HALT. Else dmemREN|dmemWEN -> DSERV (data strictly before instruction,
//   the pipeline stalls fetch behind data); else imemREN -> ISERV; else stay. On entry the address, store data
//   and kind (R/W) are latched; ram* driven only from latched copies. dmemREN&dmemWEN together: write wins.
//  DSERV/ISERV: ramREN/ramWEN/ramaddr/ramstore held stable every cycle. Counter increments per cycle.
//   ramstate==ACCESS -> capture ramload into dmemload (data read) or imemload (fetch); go to RESP.
//   ramstate==ERROR, or counter reaches TIMEOUT -> ERR. FREE/BUSY -> stay.
//  RESP (exactly 1 cycle): ihit or dhit=1 for the serviced kind; ram strobes 0; counter cleared; -> IDLE.
//   Hit is suppressed (0) if the originating request is no longer asserted in RESP; RAM write still done.
//  Latency: minimum 3 cycles request->hit (IDLE, SERV with ACCESS, RESP). Never ihit and dhit together.
//  IDLE always samples fresh requests, so a request still high in the RESP cycle is not serviced twice.
//  HALT: halted=1, all strobes 0, requests ignored; leaves only via reset. halt mid-service: finish, then HALT.
//  ERR: error=1, strobes 0, no hits; leaves only via reset.
//  Reset mid-service: RAM strobes drop immediately; pending access abandoned, no hit emitted.
// TESTING
//  T1 imemREN=1 addr 0x0, RAM ACCESS on 1st SERV cycle, ramload 0x3C010001 -> ihit at cycle 3, imemload 0x3C010001.
//  T2 imemREN and dmemREN both high, dmemaddr 0x80 -> ramaddr 0x80 first, dhit; then ramaddr 0x0, ihit.
//  T3 dmemWEN=1 addr 0x40 store 0xDEADBEEF, RAM BUSY 4 cycles -> ramWEN stable 5 cycles, dhit 1 pulse, load unchanged.
//  T4 ramstate stuck BUSY, TIMEOUT=8 -> error=1 after 8 SERV cycles, no hit, stays until nRST.
//  T5 halt=1 during DSERV -> dhit delivered, then halted=1, later imemREN ignored (ramREN stays 0).
//  T6 nRST pulsed low mid-DSERV -> ramREN/ramWEN 0 same cycle, no dhit; after release fresh fetch serviced normally.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter
// Responder side of the datapath/cache interface. Arbitrates instruction-fetch
// and data requests onto one shared single-port RAM of variable latency.
// Data requests are served before instruction fetches. Hit pulses and load
// data are returned, and halt/error status is reported. HALT and ERR are
// terminal states that are left only through reset.

module mem_request_arbiter #(
  parameter int WORD_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255   // 1..255, limited by the 8-bit service counter
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              halt,
  input  logic              imemREN,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmemREN,
  input  logic              dmemWEN,
  input  logic [ADDR_W-1:0] dmemaddr,
  input  logic [WORD_W-1:0] dmemstore,
  output logic              ihit,
  output logic              dhit,
  output logic [WORD_W-1:0] imemload,
  output logic [WORD_W-1:0] dmemload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              halted,
  output logic              error
);

  // RAM handshake encoding.
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // Controller states.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DSERV = 3'd1;
  localparam logic [2:0] S_ISERV = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [7:0]        counter;
  logic [7:0]        counter_inc;
  logic              serving;
  logic              start;

  // Copies of the request taken when leaving IDLE. The RAM is driven only
  // from these, so it sees a stable request for the whole access.
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_store;
  logic              lat_write;   // data write (wins over a simultaneous read)
  logic              lat_data;    // 1: data request, 0: instruction fetch

  assign serving     = (state == S_DSERV) || (state == S_ISERV);
  assign counter_inc = counter + 8'd1;
  assign start       = (state == S_IDLE) && !halt && (dmemREN || dmemWEN || imemREN);

  // Next-state selection.
  always_comb begin
    // NOTE: default first, so paths that do not assign state_next cannot infer a latch.
    state_next = state;
    case (state)
      S_IDLE: begin
        if (halt)                        state_next = S_HALT;
        else if (dmemREN || dmemWEN)     state_next = S_DSERV;
        else if (imemREN)                state_next = S_ISERV;
      end
      S_DSERV, S_ISERV: begin
        if (ramstate == RAM_ACCESS)      state_next = S_RESP;
        else if (ramstate == RAM_ERROR)  state_next = S_ERR;
        else if (counter_inc == TIMEOUT_CNT) state_next = S_ERR;
      end
      S_RESP:  state_next = S_IDLE;
      S_HALT:  state_next = S_HALT;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nRST) state <= S_IDLE;
    else       state <= state_next;
  end

  // Service counter: counts cycles spent waiting on the RAM, cleared otherwise.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        counter <= '0;
    else if (serving) counter <= counter_inc;
    else              counter <= '0;
  end

  // Latch the winning request when service starts.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lat_addr  <= '0;
      lat_store <= '0;
      lat_write <= 1'b0;
      lat_data  <= 1'b0;
    end else if (start) begin
      if (dmemREN || dmemWEN) begin
        lat_addr  <= dmemaddr;
        lat_store <= dmemstore;
        lat_write <= dmemWEN;
        lat_data  <= 1'b1;
      end else begin
        lat_addr  <= imemaddr;
        lat_store <= '0;
        lat_write <= 1'b0;
        lat_data  <= 1'b0;
      end
    end
  end

  // Capture RAM read data into the load register of the serviced kind.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      imemload <= '0;
      dmemload <= '0;
    end else if (serving && (ramstate == RAM_ACCESS)) begin
      if (state == S_ISERV)  imemload <= ramload;
      else if (!lat_write)   dmemload <= ramload;
    end
  end

  // RAM strobes, hit pulses and status decoded from state. Async reset of the
  // state register therefore drops the strobes in the same cycle.
  always_comb begin
    ramREN   = serving && !lat_write;
    ramWEN   = serving && lat_write;
    ramaddr  = serving ? lat_addr : '0;
    ramstore = (serving && lat_write) ? lat_store : '0;
    // A hit is only reported while the originating request is still asserted.
    ihit     = (state == S_RESP) && !lat_data && imemREN;
    dhit     = (state == S_RESP) && lat_data && (lat_write ? dmemWEN : dmemREN);
    halted   = (state == S_HALT);
    error    = (state == S_ERR);
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter
// Directed bench: a table of single-request vectors with hand-computed hit
// kind, latency, strobe count, RAM address and load value, followed by
// hand-written sequences for priority, hit suppression, reset mid-service,
// halt, timeout and RAM error. A small behavioural RAM answers the strobes.

module tb_mem_request_arbiter;

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        halt;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        ihit;
  logic        dhit;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        halted;
  logic        error;

  mem_request_arbiter #(.WORD_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .halted(halted), .error(error)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural RAM ----------------
  logic [31:0] mem [0:255];
  int          wait_cnt = 0;
  int          busy_cycles = 0;
  logic        stuck_busy = 1'b0;
  logic        force_err  = 1'b0;

  always_comb begin
    ramload = mem[ramaddr[9:2]];
    if (!(ramREN || ramWEN))      ramstate = RAM_FREE;
    else if (force_err)           ramstate = RAM_ERROR;
    else if (stuck_busy)          ramstate = RAM_BUSY;
    else if (wait_cnt >= busy_cycles) ramstate = RAM_ACCESS;
    else                          ramstate = RAM_BUSY;
  end

  always @(posedge CLK) begin
    if (ramREN || ramWEN) wait_cnt <= wait_cnt + 1;
    else                  wait_cnt <= 0;
    if (ramWEN && ramstate == RAM_ACCESS) mem[ramaddr[9:2]] <= ramstore;
  end

  // Both hits together must never happen.
  int dual_cnt = 0;
  always @(negedge CLK) if (ihit && dhit) dual_cnt <= dual_cnt + 1;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        i_ren;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] store;
    int          busy;
    logic        exp_ihit;
    logic        exp_dhit;
    int          exp_cycles;   // request cycle counted as 1
    int          exp_strobes;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [31:0] exp_load;     // imemload for fetches, dmemload for data
  } vec_t;

  vec_t vecs [8];

  // Waits (bounded) for a hit, recording what the RAM port showed meanwhile.
  task automatic wait_hit(output logic gi, output logic gd, output int cyc, output int strobes,
                          output logic [31:0] addr_seen, output logic [31:0] store_seen,
                          output logic wen_seen, output logic stable);
    gi = 1'b0; gd = 1'b0; cyc = 1; strobes = 0;
    addr_seen = '0; store_seen = '0; wen_seen = 1'b0; stable = 1'b1;
    while (cyc < 60) begin
      @(negedge CLK);
      cyc++;
      if (ramREN || ramWEN) begin
        if (ramREN === ramWEN) stable = 1'b0;
        if (strobes == 0) begin
          addr_seen = ramaddr; store_seen = ramstore; wen_seen = ramWEN;
        end else if (ramaddr !== addr_seen || ramstore !== store_seen || ramWEN !== wen_seen) begin
          stable = 1'b0;
        end
        strobes++;
      end
      if (ihit || dhit) begin
        gi = ihit; gd = dhit;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic gi, gd, wen_seen, stable;
    int cyc, strobes;
    logic [31:0] addr_seen, store_seen;
    busy_cycles = v.busy;
    imemaddr = v.i_addr; dmemaddr = v.d_addr; dmemstore = v.store;
    imemREN = v.i_ren; dmemREN = v.d_ren; dmemWEN = v.d_wen;
    wait_hit(gi, gd, cyc, strobes, addr_seen, store_seen, wen_seen, stable);
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    check($sformatf("v%0d ihit", idx), 32'(gi), 32'(v.exp_ihit));
    check($sformatf("v%0d dhit", idx), 32'(gd), 32'(v.exp_dhit));
    check($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.exp_cycles));
    check($sformatf("v%0d strobe_cycles", idx), 32'(strobes), 32'(v.exp_strobes));
    check($sformatf("v%0d ramaddr", idx), addr_seen, v.exp_addr);
    check($sformatf("v%0d ramWEN", idx), 32'(wen_seen), 32'(v.exp_wen));
    check($sformatf("v%0d stable", idx), 32'(stable), 32'd1);
    if (v.d_wen) check($sformatf("v%0d ramstore", idx), store_seen, v.store);
    if (v.exp_ihit) check($sformatf("v%0d imemload", idx), imemload, v.exp_load);
    else            check($sformatf("v%0d dmemload", idx), dmemload, v.exp_load);
    @(negedge CLK);
    @(negedge CLK);
    check($sformatf("v%0d idle_after", idx), 32'(ramREN || ramWEN), 32'd0);
  endtask

  // Pulse reset between two negedges; returns on a negedge.
  task automatic do_reset();
    #2 nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic gi, gd, wen_seen, stable;
    int cyc, strobes, cnt_a, cnt_b;
    logic [31:0] addr_seen, store_seen;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h3C01_0001;
    mem[1]  = 32'h2042_0004;
    mem[2]  = 32'h8C43_0008;
    mem[32] = 32'h1234_5678;

    //            iR    dR    dW    iaddr        daddr        store         busy ih    dh    cyc str addr         wen   load
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,      32'h3F0,     32'h0,         0, 1'b1, 1'b0, 3,  1, 32'h0,      1'b0, 32'h3C01_0001};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h3F0,    32'h80,      32'h0,         0, 1'b0, 1'b1, 3,  1, 32'h80,     1'b0, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0,      32'h40,      32'hDEAD_BEEF, 4, 1'b0, 1'b1, 7,  5, 32'h40,     1'b1, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,      32'h40,      32'h0,         2, 1'b0, 1'b1, 5,  3, 32'h40,     1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0,      32'h44,      32'hCAFE_F00D, 1, 1'b0, 1'b1, 4,  2, 32'h44,     1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,      32'h44,      32'h0,         0, 1'b0, 1'b1, 3,  1, 32'h44,     1'b0, 32'hCAFE_F00D};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h4,      32'h80,      32'h0,         3, 1'b1, 1'b0, 6,  4, 32'h4,      1'b0, 32'h2042_0004};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h8,      32'h0,       32'h0,         7, 1'b1, 1'b0, 10, 8, 32'h8,      1'b0, 32'h8C43_0008};

    nRST = 1'b0; halt = 1'b0;
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0;

    // Reset state, before any clock edge.
    #3;
    check("rst ihit", 32'(ihit), 32'd0);
    check("rst dhit", 32'(dhit), 32'd0);
    check("rst ram_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    check("rst ramaddr", ramaddr, 32'd0);
    check("rst status", {30'd0, halted, error}, 32'd0);
    check("rst imemload", imemload, 32'd0);
    check("rst dmemload", dmemload, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Single-request vectors.
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Data and fetch together: data first, then the still-held fetch.
    busy_cycles = 0;
    imemaddr = 32'h0;  imemREN = 1'b1;
    dmemaddr = 32'h80; dmemREN = 1'b1;
    wait_hit(gi, gd, cyc, strobes, addr_seen, store_seen, wen_seen, stable);
    dmemREN = 1'b0;
    check("prio first dhit", 32'(gd), 32'd1);
    check("prio first ihit", 32'(gi), 32'd0);
    check("prio first ramaddr", addr_seen, 32'h80);
    check("prio dmemload", dmemload, 32'h1234_5678);
    wait_hit(gi, gd, cyc, strobes, addr_seen, store_seen, wen_seen, stable);
    imemREN = 1'b0;
    check("prio second ihit", 32'(gi), 32'd1);
    check("prio second ramaddr", addr_seen, 32'h0);
    check("prio imemload", imemload, 32'h3C01_0001);
    @(negedge CLK);

    // Write whose request is dropped mid-service: no hit, write still done.
    busy_cycles = 2;
    dmemaddr = 32'h48; dmemstore = 32'h0BAD_F00D; dmemWEN = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ihit || dhit) cnt_a++;
      if (ramWEN && ramaddr == 32'h48) cnt_b++;
      if (i == 0) dmemWEN = 1'b0;
    end
    check("drop hits", 32'(cnt_a), 32'd0);
    check("drop wen_cycles", 32'(cnt_b), 32'd3);
    busy_cycles = 0;
    dmemaddr = 32'h48; dmemREN = 1'b1;
    wait_hit(gi, gd, cyc, strobes, addr_seen, store_seen, wen_seen, stable);
    dmemREN = 1'b0;
    check("drop readback dhit", 32'(gd), 32'd1);
    check("drop readback data", dmemload, 32'h0BAD_F00D);
    @(negedge CLK);

    // Reset in the middle of a data read.
    busy_cycles = 5;
    dmemaddr = 32'h80; dmemREN = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("midrst ramREN before", 32'(ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("midrst ramREN", 32'(ramREN), 32'd0);
    check("midrst ramWEN", 32'(ramWEN), 32'd0);
    dmemREN = 1'b0;
    @(negedge CLK);
    check("midrst dhit", 32'(dhit), 32'd0);
    check("midrst dmemload", dmemload, 32'd0);
    nRST = 1'b1;
    @(negedge CLK);
    run_vec(100, vecs[6]);

    // Halt raised during a data service: finish it, then halt.
    busy_cycles = 2;
    dmemaddr = 32'h80; dmemREN = 1'b1;
    @(negedge CLK);
    halt = 1'b1;
    wait_hit(gi, gd, cyc, strobes, addr_seen, store_seen, wen_seen, stable);
    dmemREN = 1'b0;
    check("halt dhit", 32'(gd), 32'd1);
    check("halt dmemload", dmemload, 32'h1234_5678);
    @(negedge CLK);
    @(negedge CLK);
    check("halt halted", 32'(halted), 32'd1);
    imemaddr = 32'h0; imemREN = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (ramREN || ramWEN || ihit) cnt_a++;
    end
    check("halt ignores fetch", 32'(cnt_a), 32'd0);
    check("halt sticky", 32'(halted), 32'd1);
    imemREN = 1'b0; halt = 1'b0;
    do_reset();
    check("halt cleared by reset", 32'(halted), 32'd0);

    // RAM stuck busy: timeout after 8 service cycles.
    stuck_busy = 1'b1;
    imemaddr = 32'h8; imemREN = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (ramREN) cnt_a++;
      if (ihit || dhit) cnt_b++;
    end
    check("tmo ren_cycles", 32'(cnt_a), 32'd8);
    check("tmo hits", 32'(cnt_b), 32'd0);
    check("tmo error", 32'(error), 32'd1);
    stuck_busy = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge CLK);
    check("tmo error sticky", 32'(error), 32'd1);
    check("tmo strobes off", 32'(ramREN || ramWEN || ihit), 32'd0);
    imemREN = 1'b0;
    do_reset();
    check("tmo error cleared", 32'(error), 32'd0);

    // RAM reports ERROR.
    force_err = 1'b1;
    dmemaddr = 32'h80; dmemREN = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (ihit || dhit) cnt_a++;
    end
    check("ramerr error", 32'(error), 32'd1);
    check("ramerr hits", 32'(cnt_a), 32'd0);
    check("ramerr strobes off", 32'(ramREN || ramWEN), 32'd0);
    dmemREN = 1'b0; force_err = 1'b0;
    do_reset();
    check("ramerr cleared", 32'(error), 32'd0);

    check("no dual hit", 32'(dual_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
